// File: rtl/alu_v2.sv
// Pipelined-handshake ALU with one result register stage and an optional
// iterative shift-add multiplier compiled in by defining ALU_V2_MUL_EN.
module alu_v2 #(
  parameter int          WIDTH     = 32,
  parameter logic [7:0]  FILL_BYTE = 8'hF7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic [7:0]       error_vector,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_V2_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

  state_t           r_state_reg;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_out_reg;
  logic             r_zero_reg;
  logic             r_sign_reg;
  logic [7:0]       r_err_reg;

  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] w_result;
  logic [7:0]       w_err;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SH_W-1:0]  w_shamt;
  logic             w_accept;
  logic             w_is_mul;

  generate
    for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_fill
      assign w_fill[gi*8 +: 8] = FILL_BYTE;
    end
  endgenerate

  assign w_sum   = a + b;
  assign w_diff  = a - b;
  assign w_shamt = b[SH_W-1:0];

  always_comb begin
    w_result = w_fill;
    w_err    = 8'h01;
    unique case (op_code)
      4'b0000: begin
        w_result = w_sum;
        w_err    = {6'd0, (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]), 1'b0};
      end
      4'b0001: begin
        w_result = w_diff;
        w_err    = {5'd0, (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]), 2'b00};
      end
      4'b0010: begin w_result = a & b;                            w_err = 8'h00; end
      4'b0011: begin w_result = a | b;                            w_err = 8'h00; end
      4'b0100: begin w_result = a ^ b;                            w_err = 8'h00; end
      4'b0101: begin w_result = a << w_shamt;                     w_err = 8'h00; end
      4'b0110: begin w_result = a >> w_shamt;                     w_err = 8'h00; end
      4'b0111: begin w_result = WIDTH'($signed(a) >>> w_shamt);   w_err = 8'h00; end
      4'b1000: begin
        w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        w_err    = 8'h00;
      end
      4'b1001: begin
        w_result = {{(WIDTH-1){1'b0}}, (a < b)};
        w_err    = 8'h00;
      end
      default: begin
        w_result = w_fill;
        w_err    = 8'h01;
      end
    endcase
  end

`ifdef ALU_V2_MUL_EN
  logic [WIDTH-1:0] r_mcand_reg;
  logic [WIDTH-1:0] r_mplier_reg;
  logic [WIDTH-1:0] r_acc_reg;
  logic [SH_W-1:0]  r_cnt_reg;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_mul_last;

  assign w_is_mul   = (op_code == 4'b1010);
  assign busy       = (r_state_reg == MUL);
  assign w_acc_next = r_acc_reg + (r_mplier_reg[0] ? r_mcand_reg : '0);
  assign w_mul_last = (r_cnt_reg == SH_W'(WIDTH - 1));
`else
  assign w_is_mul = 1'b0;
  assign busy     = 1'b0;
`endif

  assign out_valid    = (r_state_reg == HOLD);
  assign in_ready     = !rst && !busy && (!out_valid || out_ready);
  assign w_accept     = in_valid && in_ready;
  assign out          = r_out_reg;
  assign zero_flag    = r_zero_reg;
  assign sign_flag    = r_sign_reg;
  assign error_vector = r_err_reg;

  always_comb begin
    w_state_next = r_state_reg;
    case (r_state_reg)
`ifdef ALU_V2_MUL_EN
      MUL:  if (w_mul_last) w_state_next = HOLD;
`endif
      IDLE, HOLD: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? state_t'(2'd1) : HOLD;
        end else if (r_state_reg == HOLD && out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state_reg <= IDLE;
    else     r_state_reg <= w_state_next;
  end

  // Result registers only change on a single-cycle accept or the final multiply step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_reg  <= '0;
      r_zero_reg <= 1'b0;
      r_sign_reg <= 1'b0;
      r_err_reg  <= 8'h00;
    end else if (w_accept && !w_is_mul) begin
      r_out_reg  <= w_result;
      r_zero_reg <= (w_result == '0);
      r_sign_reg <= w_result[WIDTH-1];
      r_err_reg  <= w_err;
    end
`ifdef ALU_V2_MUL_EN
    else if (r_state_reg == MUL && w_mul_last) begin
      r_out_reg  <= w_acc_next;
      r_zero_reg <= (w_acc_next == '0);
      r_sign_reg <= w_acc_next[WIDTH-1];
      r_err_reg  <= 8'h00;
    end
`endif
  end

`ifdef ALU_V2_MUL_EN
  // One multiplier bit per cycle, LSB first; the multiplicand shifts left to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand_reg  <= '0;
      r_mplier_reg <= '0;
      r_acc_reg    <= '0;
      r_cnt_reg    <= '0;
    end else if (w_accept && w_is_mul) begin
      r_mcand_reg  <= a;
      r_mplier_reg <= b;
      r_acc_reg    <= '0;
      r_cnt_reg    <= '0;
    end else if (r_state_reg == MUL) begin
      r_acc_reg    <= w_acc_next;
      r_mcand_reg  <= r_mcand_reg << 1;
      r_mplier_reg <= r_mplier_reg >> 1;
      r_cnt_reg    <= r_cnt_reg + 1'b1;
    end
  end
`endif

endmodule
